alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_pkg.sv | 25 ++
 rtl/alu_seq_if.sv | 36 +++
 rtl/alu_seq_fifo.sv | 64 ++++++
 rtl/alu_seq.sv | 115 +++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and widths for the ALU command sequencer.
//   OpW/SelW/TagW/CntW/SettleW : operand, select, tag, done-counter and settle-counter widths
//   cmd_t                      : one queued command (a, b, sel)
//   state_e                    : sequencer FSM states
package alu_seq_pkg;

  localparam int unsigned OpW     = 4;
  localparam int unsigned SelW    = 3;
  localparam int unsigned TagW    = 4;
  localparam int unsigned CntW    = 8;
  localparam int unsigned SettleW = 4;

  typedef struct packed {
    logic [OpW-1:0]  a;
    logic [OpW-1:0]  b;
    logic [SelW-1:0] sel;
  } cmd_t;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StResp
  } state_e;

endpackage

// File: rtl/alu_seq_if.sv
// Bus bundle for alu_seq: command in, external ALU drive/return, response out, status.
//   slave  : sequencer view (takes commands, drives ALU and responses)
//   master : environment view (offers commands, supplies ALU result, consumes responses)
interface alu_seq_if;
  import alu_seq_pkg::*;

  logic            cmd_valid;
  logic            cmd_ready;
  logic [OpW-1:0]  cmd_a;
  logic [OpW-1:0]  cmd_b;
  logic [SelW-1:0] cmd_sel;
  logic [OpW-1:0]  alu_a;
  logic [OpW-1:0]  alu_b;
  logic [SelW-1:0] alu_sel;
  logic [OpW-1:0]  alu_out;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [OpW-1:0]  rsp_data;
  logic [SelW-1:0] rsp_sel;
  logic [TagW-1:0] rsp_tag;
  logic            busy;
  logic [CntW-1:0] done_cnt;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_sel, alu_out, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_sel, rsp_tag,
           busy, done_cnt
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_sel, alu_out, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_sel, rsp_tag,
           busy, done_cnt
  );

endinterface

// File: rtl/alu_seq_fifo.sv
// Command FIFO for alu_seq. DEPTH entries (power of two), asynchronous active-low reset.
//   clk, rst_n   : clock, async active-low reset
//   push, wdata  : write request (ignored when full, even if popping this cycle)
//   pop, rdata   : read request (ignored when empty); rdata shows the head entry
//   full, empty  : occupancy flags
module alu_seq_fifo
  import alu_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  cmd_t wdata,
  output cmd_t rdata,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

  cmd_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == FullCount);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// ALU command sequencer. Queues commands, drives them one at a time to an external
// combinational 4-bit ALU, holds operands SETTLE cycles, samples the result and presents
// it as a tagged response.
//   clk, rst_n : clock, async active-low reset
//   bus        : alu_seq_if.slave (command, ALU drive/return, response, busy, done_cnt)
//   DEPTH      : command FIFO entries (power of two, 2..16)
//   SETTLE     : cycles operands are held before sampling alu_out (1..15)
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned SETTLE = 1
) (
  input logic      clk,
  input logic      rst_n,
  alu_seq_if.slave bus
);

  cmd_t fifo_wdata, fifo_rdata;
  logic fifo_full, fifo_empty, fifo_pop;

  assign fifo_wdata = cmd_t'{a: bus.cmd_a, b: bus.cmd_b, sel: bus.cmd_sel};

  alu_seq_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (bus.cmd_valid),
    .pop  (fifo_pop),
    .wdata(fifo_wdata),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  state_e             state_q, state_d;
  logic [SettleW-1:0] cnt_q, cnt_d;
  cmd_t               op_q, op_d;
  logic [OpW-1:0]     data_q, data_d;
  logic [TagW-1:0]    tag_q, tag_d;
  logic [TagW-1:0]    next_tag_q, next_tag_d;
  logic [CntW-1:0]    done_q, done_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    data_d     = data_q;
    tag_d      = tag_q;
    next_tag_d = next_tag_q;
    done_d     = done_q;
    fifo_pop   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          op_d       = fifo_rdata;
          tag_d      = next_tag_q;
          next_tag_d = next_tag_q + 1'b1;
          cnt_d      = SettleW'(SETTLE - 1);
          state_d    = StDrive;
        end
      end
      StDrive: begin
        if (cnt_q == '0) begin
          data_d  = bus.alu_out;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          done_d  = done_q + 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      op_q       <= '0;
      data_q     <= '0;
      tag_q      <= '0;
      next_tag_q <= '0;
      done_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      data_q     <= data_d;
      tag_q      <= tag_d;
      next_tag_q <= next_tag_d;
      done_q     <= done_d;
    end
  end

  // op_q doubles as the ALU drive and the response select; it is never cleared in idle.
  assign bus.cmd_ready = !fifo_full;
  assign bus.alu_a     = op_q.a;
  assign bus.alu_b     = op_q.b;
  assign bus.alu_sel   = op_q.sel;
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_data  = data_q;
  assign bus.rsp_sel   = op_q.sel;
  assign bus.rsp_tag   = tag_q;
  assign bus.busy      = (state_q != StIdle) || !fifo_empty;
  assign bus.done_cnt  = done_q;

endmodule
